pokey_mux_arbiter: RTL and testbench

- Round-robin arbiter sharing one 4-way mux/demux path between four requesters (audio or scan channels).
- Grants one requester at a time for a fixed number of cycles.
- Drives the 2-bit select shared by the mux and demux, plus a path-valid strobe.
- Sits between channel logic and the select inputs of the mux/demux pair in POKEY.

---
 rtl/pokey_mux_arbiter.sv | 122 ++++++++++++
 tb/tb_pokey_mux_arbiter.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pokey_mux_arbiter.sv
// Round-robin owner arbiter for the shared POKEY 4-way mux/demux select path.
// Define ARB_FIXED_PRIO_EN to make channel 0 the highest fixed priority instead.
module pokey_mux_arbiter #(
  parameter int HOLD_CYCLES = 4,
  parameter int CNT_W       = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic [1:0] sel,
  output logic       valid,
  output logic       done,
  output logic       busy
);

  // Handshake: req[i] is a level held by channel i until gnt[i] rises; the
  // owner keeps the path while req[i] stays high, up to HOLD_CYCLES cycles.
  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);

  state_t           state, state_nx;
  logic [1:0]       ptr, ptr_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [3:0]       gnt_nx;
  logic [1:0]       sel_nx;
  logic             done_nx;
  logic             win_found;
  logic [1:0]       win;
`ifndef ARB_FIXED_PRIO_EN
  logic [1:0]       idx;
`endif

  // Winner search; descending scan so the lowest offset assigns last.
  always_comb begin
    win_found = 1'b0;
    win       = 2'd0;
`ifdef ARB_FIXED_PRIO_EN
    for (int i = 3; i >= 0; i--) begin
      if (req[i]) begin
        win_found = 1'b1;
        win       = 2'(i);
      end
    end
`else
    idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      idx = ptr + 2'(i);
      if (req[idx]) begin
        win_found = 1'b1;
        win       = idx;
      end
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      ptr   <= 2'd0;
      cnt   <= '0;
      gnt   <= 4'd0;
      sel   <= 2'd0;
      valid <= 1'b0;
      done  <= 1'b0;
      busy  <= 1'b0;
    end else begin
      state <= state_nx;
      ptr   <= ptr_nx;
      cnt   <= cnt_nx;
      gnt   <= gnt_nx;
      sel   <= sel_nx;
      valid <= |gnt_nx;
      done  <= done_nx;
      busy  <= (state_nx == GRANT);
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (en && win_found) state_nx = GRANT;
      GRANT:   if (!req[sel] || cnt == '0) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // done is predicted one cycle early so it lands in the last grant cycle.
  always_comb begin
    gnt_nx  = 4'd0;
    sel_nx  = sel;
    cnt_nx  = cnt;
    ptr_nx  = ptr;
    done_nx = 1'b0;
    case (state)
      IDLE: begin
        if (en && win_found) begin
          gnt_nx  = 4'b0001 << win;
          sel_nx  = win;
          cnt_nx  = HOLD_LAST;
          done_nx = (HOLD_LAST == '0);
`ifdef ARB_FIXED_PRIO_EN
          ptr_nx  = 2'd0;
`else
          ptr_nx  = win + 2'd1;
`endif
        end
      end
      GRANT: begin
        if (req[sel] && cnt != '0) begin
          gnt_nx  = gnt;
          cnt_nx  = cnt - CNT_W'(1);
          done_nx = (cnt == CNT_W'(1));
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_pokey_mux_arbiter.sv
// Bench for pokey_mux_arbiter: owner/age reference model, directed scenarios, random run.
module tb_pokey_mux_arbiter;
  localparam int HOLD = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en  = 1'b0;
  logic [3:0] req = 4'd0;
  logic [3:0] gnt, gnt1;
  logic [1:0] sel, sel1;
  logic       valid, done, busy, valid1, done1, busy1;

  int checks = 0;
  int errors = 0;
  logic [1:0] exp_q[$];

  pokey_mux_arbiter #(.HOLD_CYCLES(HOLD), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .en(en), .req(req),
    .gnt(gnt), .sel(sel), .valid(valid), .done(done), .busy(busy));

  pokey_mux_arbiter #(.HOLD_CYCLES(1), .CNT_W(8)) dut1 (
    .clk(clk), .rst(rst), .en(en), .req(req),
    .gnt(gnt1), .sel(sel1), .valid(valid1), .done(done1), .busy(busy1));

  always #5 clk = ~clk;

  // Reference model: who owns the path, how many cycles it has held it.
  int m_owner = -1;
  int m_age   = 0;
  int m_ptr   = 0;
  int m_sel   = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_owner = -1; m_age = 0; m_ptr = 0; m_sel = 0;
    end else if (m_owner >= 0) begin
      if (!req[m_owner] || m_age == HOLD) m_owner = -1;
      else m_age = m_age + 1;
    end else if (en && req != 4'd0) begin
      int c;
      c = -1;
`ifdef ARB_FIXED_PRIO_EN
      for (int k = 0; k < 4; k++) if (c < 0 && req[k]) c = k;
`else
      for (int k = 0; k < 4; k++) if (c < 0 && req[(m_ptr + k) % 4]) c = (m_ptr + k) % 4;
      m_ptr = (c + 1) % 4;
`endif
      m_owner = c; m_age = 1; m_sel = c;
    end
  end

  function automatic logic [8:0] exp_vec();
    logic [3:0] g;
    g = (m_owner >= 0) ? 4'(1 << m_owner) : 4'd0;
    return {g, 2'(m_sel), m_owner >= 0, (m_owner >= 0 && m_age == HOLD), m_owner >= 0};
  endfunction

  task automatic do_reset();
    rst = 1'b1; req = 4'd0; en = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({gnt, sel, valid, done, busy} !== 9'd0) begin
      errors++; $display("FAIL reset_idle obs=%h exp=0", {gnt, sel, valid, done, busy});
    end
    req = 4'b0100;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (gnt !== 4'b0100 || busy !== 1'b1) begin
      errors++; $display("FAIL reset_pregrant gnt=%b busy=%b exp gnt=0100 busy=1", gnt, busy);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({gnt, sel, valid, done, busy} !== 9'd0) begin
      errors++; $display("FAIL reset_async obs=%h exp=0", {gnt, sel, valid, done, busy});
    end
    @(negedge clk);
    rst = 1'b0; req = 4'd0;
  endtask

  task automatic test_single();
    do_reset();
    req = 4'b0010;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      checks++;
      if ({gnt, sel, valid, done, busy} !== exp_vec()) begin
        errors++; $display("FAIL single_model cyc=%0d obs=%h exp=%h", i, {gnt, sel, valid, done, busy}, exp_vec());
      end
      if (i == 1 || i == 4 || i == 5 || i == 6) begin
        checks++;
        if ((i == 1 && (gnt !== 4'b0010 || sel !== 2'd1 || done !== 1'b0)) ||
            (i == 4 && (gnt !== 4'b0010 || done !== 1'b1)) ||
            (i == 5 && (gnt !== 4'b0000 || valid !== 1'b0)) ||
            (i == 6 && gnt !== 4'b0010)) begin
          errors++; $display("FAIL single_timing cyc=%0d gnt=%b sel=%0d done=%b", i, gnt, sel, done);
        end
      end
    end
    req = 4'd0;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic test_round_robin();
    logic prev_valid;
    do_reset();
    exp_q = {2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    req = 4'b1111;
    prev_valid = 1'b0;
    for (int i = 0; i < 40 && exp_q.size() > 0; i++) begin
      @(negedge clk);
      checks++;
      if ({gnt, sel, valid, done, busy} !== exp_vec()) begin
        errors++; $display("FAIL rr_model cyc=%0d obs=%h exp=%h", i, {gnt, sel, valid, done, busy}, exp_vec());
      end
      if (valid && !prev_valid) begin
        logic [1:0] e;
        e = exp_q.pop_front();
        checks++;
        if (sel !== e) begin
          errors++; $display("FAIL rr_order sel=%0d exp=%0d", sel, e);
        end
      end
      prev_valid = valid;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL rr_timeout left=%0d exp=0", exp_q.size());
    end
    req = 4'd0;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic test_wrap();
    logic prev_valid;
    do_reset();
    req = 4'b1000;
    for (int i = 0; i < 5 && gnt !== 4'b1000; i++) @(negedge clk);
    checks++;
    if (gnt !== 4'b1000) begin
      errors++; $display("FAIL wrap_setup gnt=%b exp=1000", gnt);
    end
    req = 4'b1010;
    exp_q = {2'd1, 2'd3, 2'd1};
    prev_valid = 1'b1;
    for (int i = 0; i < 40 && exp_q.size() > 0; i++) begin
      @(negedge clk);
      if (valid && !prev_valid) begin
        logic [1:0] e;
        e = exp_q.pop_front();
        checks++;
        if (sel !== e) begin
          errors++; $display("FAIL wrap_order sel=%0d exp=%0d", sel, e);
        end
      end
      prev_valid = valid;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL wrap_timeout left=%0d exp=0", exp_q.size());
    end
    req = 4'd0;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic test_early_release();
    int done_seen;
    do_reset();
    done_seen = 0;
    req = 4'b0100;
    @(negedge clk);
    req = 4'b0101;
    @(negedge clk);
    if (done) done_seen++;
    checks++;
    if (gnt !== 4'b0100) begin
      errors++; $display("FAIL early_owner gnt=%b exp=0100", gnt);
    end
    req = 4'b0001;
    @(negedge clk);
    if (done) done_seen++;
    checks++;
    if (gnt !== 4'b0000 || valid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL early_release gnt=%b valid=%b busy=%b exp 0000/0/0", gnt, valid, busy);
    end
    @(negedge clk);
    checks++;
    if (gnt !== 4'b0001 || sel !== 2'd0) begin
      errors++; $display("FAIL early_next gnt=%b sel=%0d exp=0001/0", gnt, sel);
    end
    checks++;
    if (done_seen != 0) begin
      errors++; $display("FAIL early_done seen=%0d exp=0", done_seen);
    end
    req = 4'd0;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic test_enable();
    int hi;
    int dn;
    do_reset();
    en = 1'b0; req = 4'b0001;
    hi = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (gnt != 4'd0) hi++;
    end
    checks++;
    if (hi != 0) begin
      errors++; $display("FAIL en_block grant_cycles=%0d exp=0", hi);
    end
    en = 1'b1;
    @(negedge clk);
    en = 1'b0;
    hi = 1; dn = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (gnt == 4'b0001) hi++;
      if (done) dn++;
    end
    checks++;
    if (hi != HOLD || dn != 1) begin
      errors++; $display("FAIL en_midgrant held=%0d done=%0d exp=%0d/1", hi, dn, HOLD);
    end
    checks++;
    if (gnt !== 4'd0) begin
      errors++; $display("FAIL en_after gnt=%b exp=0000", gnt);
    end
    en = 1'b1; req = 4'd0;
    @(negedge clk);
  endtask

  task automatic test_hold_one();
    do_reset();
    req = 4'b0100;
    @(negedge clk);
    checks++;
    if (gnt1 !== 4'b0100 || done1 !== 1'b1 || sel1 !== 2'd2) begin
      errors++; $display("FAIL hold1_grant gnt=%b done=%b sel=%0d exp 0100/1/2", gnt1, done1, sel1);
    end
    @(negedge clk);
    checks++;
    if (gnt1 !== 4'd0 || done1 !== 1'b0) begin
      errors++; $display("FAIL hold1_gap gnt=%b done=%b exp 0000/0", gnt1, done1);
    end
    @(negedge clk);
    checks++;
    if (gnt1 !== 4'b0100 || done1 !== 1'b1) begin
      errors++; $display("FAIL hold1_regrant gnt=%b done=%b exp 0100/1", gnt1, done1);
    end
    req = 4'd0;
    @(negedge clk);
  endtask

`ifdef ARB_FIXED_PRIO_EN
  task automatic test_fixed_prio();
    int c3;
    int c0;
    do_reset();
    req = 4'b1001;
    c3 = 0; c0 = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (gnt[3]) c3++;
      if (gnt[0]) c0++;
    end
    checks++;
    if (c3 != 0 || c0 == 0) begin
      errors++; $display("FAIL fixed_prio ch0=%0d ch3=%0d exp ch3=0", c0, c3);
    end
    req = 4'd0;
    @(negedge clk);
  endtask
`endif

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      req = req ^ 4'($urandom_range(0, 15) & $urandom_range(0, 15) & $urandom_range(0, 15));
      en = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      checks++;
      if ({gnt, sel, valid, done, busy} !== exp_vec()) begin
        errors++; $display("FAIL rand_model cyc=%0d obs=%h exp=%h", i, {gnt, sel, valid, done, busy}, exp_vec());
      end
      checks++;
      if (!$onehot0(gnt) || valid !== (|gnt)) begin
        errors++; $display("FAIL rand_onehot gnt=%b valid=%b exp onehot0/|gnt", gnt, valid);
      end
    end
    req = 4'd0; en = 1'b1;
  endtask

  initial begin
    test_reset();
    test_single();
`ifndef ARB_FIXED_PRIO_EN
    test_round_robin();
    test_wrap();
`else
    test_fixed_prio();
`endif
    test_early_release();
    test_enable();
    test_hold_one();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
